// File: rtl/int_sequencer_if.sv
// Interrupt sequencer bus: controller handshake, CPU commit-point inputs and
// redirect/mask outputs. The slave modport is the sequencer's view.
interface int_sequencer_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              in_EN;
  logic              in_break;
  logic [1:0]        in_code;
  logic              in_boundary;
  logic [ADDR_W-1:0] in_next_PC;
  logic              in_ERET;
  logic              in_EI;
  logic              in_DI;
  logic              out_IE;
  logic [3:0]        out_INM;
  logic [3:0]        out_IG;
  logic              out_jump;
  logic [ADDR_W-1:0] out_target;
  logic              out_stall;
  logic [2:0]        out_depth;
  logic              out_err;

  modport master (
    output in_EN, in_break, in_code, in_boundary, in_next_PC, in_ERET, in_EI, in_DI,
    input  out_IE, out_INM, out_IG, out_jump, out_target, out_stall, out_depth, out_err
  );

  modport slave (
    input  in_EN, in_break, in_code, in_boundary, in_next_PC, in_ERET, in_EI, in_DI,
    output out_IE, out_INM, out_IG, out_jump, out_target, out_stall, out_depth, out_err
  );
endinterface

// File: rtl/int_sequencer.sv
// Interrupt entry/exit sequencer: pushes return PC and mask, pulses the grant,
// redirects to the source vector, and unwinds the nesting stack on ERET.
module int_sequencer #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(32'h0000_0100),
  parameter int unsigned       VEC_STRIDE = 16,
  parameter int unsigned       DEPTH      = 4
) (
  input  logic           in_CLK,
  input  logic           in_RST,
  int_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    JUMP = 2'd2,
    RET  = 2'd3
  } state_t;

  localparam logic [2:0] DEPTH_MAX = 3'(DEPTH);

  state_t            state_r, state_nx_s;
  logic              ie_r, ie_nx_s;
  logic [3:0]        inm_r, inm_nx_s;
  logic [3:0]        ig_r, ig_nx_s;
  logic              jump_r, jump_nx_s;
  logic [ADDR_W-1:0] target_r, target_nx_s;
  logic [2:0]        depth_r, depth_nx_s;
  logic              err_r, err_nx_s;
  logic [1:0]        code_r, code_nx_s;
  logic              push_s;
  logic              go_s;
  logic [1:0]        push_idx_s;
  logic [1:0]        top_idx_s;

  // Storage is sized for the largest legal DEPTH; occupancy is bounded by DEPTH_MAX.
  logic [ADDR_W-1:0] stack_pc_r   [4];
  logic [3:0]        stack_mask_r [4];

  function automatic logic [3:0] thermo(input logic [1:0] k);
    logic [3:0] m;
    case (k)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      2'd2:    m = 4'b0111;
      2'd3:    m = 4'b1111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] k);
    return 4'b0001 << k;
  endfunction

  assign go_s       = bus.in_EN & bus.in_boundary;
  assign push_idx_s = depth_r[1:0];
  assign top_idx_s  = depth_r[1:0] - 2'd1;

  // Next-state and next-output decode.
  always_comb begin
    state_nx_s  = state_r;
    ie_nx_s     = ie_r;
    inm_nx_s    = inm_r;
    ig_nx_s     = 4'b0000;
    jump_nx_s   = 1'b0;
    target_nx_s = '0;
    depth_nx_s  = depth_r;
    err_nx_s    = err_r;
    code_nx_s   = code_r;
    push_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (go_s && bus.in_ERET) begin
          if (depth_r != 3'd0) begin
            inm_nx_s    = stack_mask_r[top_idx_s];
            target_nx_s = stack_pc_r[top_idx_s];
            jump_nx_s   = 1'b1;
            depth_nx_s  = depth_r - 3'd1;
            state_nx_s  = RET;
          end else begin
            err_nx_s = 1'b1;
          end
        end else if (go_s && bus.in_break) begin
          if (depth_r < DEPTH_MAX) begin
            push_s     = 1'b1;
            code_nx_s  = bus.in_code;
            ie_nx_s    = 1'b0;
            ig_nx_s    = onehot(bus.in_code);
            depth_nx_s = depth_r + 3'd1;
            state_nx_s = ACK;
          end else begin
            err_nx_s = 1'b1;
          end
        end else if (bus.in_DI) begin
          ie_nx_s = 1'b0;
        end else if (bus.in_EI) begin
          ie_nx_s = 1'b1;
        end else begin
          ie_nx_s = ie_r;
        end
      end
      ACK: begin
        // Grant is already on the bus this cycle; mask this level and below, then redirect.
        inm_nx_s    = inm_r | thermo(code_r);
        jump_nx_s   = 1'b1;
        target_nx_s = VEC_BASE + ADDR_W'(code_r) * ADDR_W'(VEC_STRIDE);
        state_nx_s  = JUMP;
      end
      JUMP: begin
        ie_nx_s    = 1'b1;
        state_nx_s = IDLE;
      end
      RET: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, output registers and nesting stack.
  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      state_r  <= IDLE;
      ie_r     <= 1'b0;
      inm_r    <= 4'b0000;
      ig_r     <= 4'b0000;
      jump_r   <= 1'b0;
      target_r <= '0;
      depth_r  <= 3'd0;
      err_r    <= 1'b0;
      code_r   <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        stack_pc_r[i]   <= '0;
        stack_mask_r[i] <= 4'b0000;
      end
    end else begin
      state_r  <= state_nx_s;
      ie_r     <= ie_nx_s;
      inm_r    <= inm_nx_s;
      ig_r     <= ig_nx_s;
      jump_r   <= jump_nx_s;
      target_r <= target_nx_s;
      depth_r  <= depth_nx_s;
      err_r    <= err_nx_s;
      code_r   <= code_nx_s;
      if (push_s) begin
        stack_pc_r[push_idx_s]   <= bus.in_next_PC;
        stack_mask_r[push_idx_s] <= inm_r;
      end
    end
  end

  assign bus.out_IE     = ie_r;
  assign bus.out_INM    = inm_r;
  assign bus.out_IG     = ig_r;
  assign bus.out_jump   = jump_r;
  assign bus.out_target = target_r;
  assign bus.out_stall  = (state_r != IDLE);
  assign bus.out_depth  = depth_r;
  assign bus.out_err    = err_r;
endmodule
